// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit APB bridge.
//   lsu_state_t : bus sequencer states (IDLE -> SETUP -> ACCESS)
//   LSU_*       : funct3 size encodings as issued by the core
//   is_legal()  : funct3/direction legality, independent of alignment
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Unsigned-load encodings have no store counterpart.
  function automatic logic is_legal(input logic [2:0] funct3, input logic we);
    case (funct3)
      LSU_B, LSU_H, LSU_W: return 1'b1;
      LSU_BU, LSU_HU:      return ~we;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering between the core and a 32-bit APB bus.
//   funct3     in  3   access size/sign encoding
//   offset     in  2   byte offset within the word (addr[1:0])
//   wdata      in  32  store data, value in the low lanes
//   prdata     in  32  raw bus read word
//   pstrb      out 4   byte strobes for the access
//   pwdata     out 32  store data replicated across all lanes
//   rdata      out 32  read data shifted down to bit 0, upper bits zero
//   misaligned out 1   access crosses its natural alignment
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] prdata,
  output logic [3:0]  pstrb,
  output logic [31:0] pwdata,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    pstrb      = 4'b0000;
    pwdata     = 32'h0;
    rdata      = 32'h0;
    misaligned = 1'b0;
    shifted    = prdata >> {offset, 3'b000};
    case (funct3)
      LSU_B, LSU_BU: begin
        pstrb  = 4'b0001 << offset;
        pwdata = {4{wdata[7:0]}};
        rdata  = {24'h0, shifted[7:0]};
      end
      LSU_H, LSU_HU: begin
        misaligned = offset[0];
        pstrb      = 4'b0011 << offset;
        pwdata     = {2{wdata[15:0]}};
        rdata      = {16'h0, shifted[15:0]};
      end
      LSU_W: begin
        misaligned = |offset;
        pstrb      = 4'b1111;
        pwdata     = wdata;
        rdata      = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_apb_bridge.sv
// Load/store unit: turns one core load/store into one APB4 SETUP/ACCESS
// transfer and stalls the core until it completes, errors or times out.
//   clk, reset        clock; asynchronous active-low reset
//   req_*             core request (valid, we, funct3, addr, wdata)
//   stall             hold PC / suppress writeback while high
//   rdata             load data aligned to bit 0 (bypassed on completion)
//   rdata_valid       1-cycle pulse on error-free load completion
//   lsu_err           1-cycle pulse on misaligned/illegal, PSLVERR or timeout
//   PADDR..PSTRB      APB requester outputs
//   PRDATA/PREADY/PSLVERR  APB completer inputs
module lsu_apb_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        lsu_err,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      paddr_q, paddr_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic [3:0]       pstrb_q, pstrb_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       offset_q, offset_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [2:0]  align_funct3;
  logic [1:0]  align_offset;
  logic [3:0]  align_pstrb;
  logic [31:0] align_pwdata;
  logic [31:0] align_rdata;
  logic        align_misaligned;

  logic        stall_c, err_c, valid_c;
  logic [31:0] rdata_c;

  // One aligner serves both directions: in IDLE it encodes the incoming
  // request, afterwards it decodes PRDATA using the latched size/offset.
  always_comb begin
    align_funct3 = funct3_q;
    align_offset = offset_q;
    if (state_q == IDLE) begin
      align_funct3 = req_funct3;
      align_offset = req_addr[1:0];
    end
  end

  lsu_lane_align u_align (
    .funct3     (align_funct3),
    .offset     (align_offset),
    .wdata      (req_wdata),
    .prdata     (PRDATA),
    .pstrb      (align_pstrb),
    .pwdata     (align_pwdata),
    .rdata      (align_rdata),
    .misaligned (align_misaligned)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    funct3_d = funct3_q;
    offset_d = offset_q;
    rdata_d  = rdata_q;
    stall_c  = 1'b0;
    err_c    = 1'b0;
    valid_c  = 1'b0;
    rdata_c  = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          if (is_legal(req_funct3, req_we) && !align_misaligned) begin
            stall_c  = 1'b1;
            paddr_d  = {req_addr[31:2], 2'b00};
            pwrite_d = req_we;
            pwdata_d = align_pwdata;
            pstrb_d  = req_we ? align_pstrb : 4'b0000;
            funct3_d = req_funct3;
            offset_d = req_addr[1:0];
            state_d  = SETUP;
          end else begin
            // Rejected without touching the bus; the core retires it at once.
            err_c = 1'b1;
          end
        end
      end
      SETUP: begin
        stall_c = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d = IDLE;
          if (PSLVERR) begin
            err_c   = 1'b1;
            rdata_c = 32'h0;
          end else if (!pwrite_q) begin
            valid_c = 1'b1;
            rdata_c = align_rdata;
            rdata_d = align_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // PREADY still low on the last allowed ACCESS cycle: abandon.
          err_c   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      paddr_q  <= 32'h0;
      pwrite_q <= 1'b0;
      pwdata_q <= 32'h0;
      pstrb_q  <= 4'b0000;
      funct3_q <= 3'b000;
      offset_q <= 2'b00;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      funct3_q <= funct3_d;
      offset_q <= offset_d;
      rdata_q  <= rdata_d;
    end
  end

  // Core-facing strobes are forced low while reset is held so a request the
  // core keeps presenting across reset cannot stall it or raise an error.
  assign stall       = stall_c & reset;
  assign lsu_err     = err_c & reset;
  assign rdata_valid = valid_c & reset;
  assign rdata       = rdata_c;

  assign PSEL    = (state_q != IDLE);
  assign PENABLE = (state_q == ACCESS);
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;

endmodule

// File: tb/tb_lsu_apb_bridge.sv
module tb_lsu_apb_bridge;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, lsu_err;
  logic [31:0] rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;

  int total = 0;
  int bad = 0;
  logic [7:0]  mem_b [0:63];
  logic [31:0] last_load;

  always #5 clk = ~clk;

  lsu_apb_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .lsu_err(lsu_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes implied by funct3; 0 marks an unknown encoding.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int b;
    b = int'(a & 32'h3C);
    return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    int b;
    b = int'(a & 32'h3C);
    for (int i = 0; i < 4; i++) mem_b[b+i] = v[8*i +: 8];
  endtask

  // Called just after a rising edge. waits<0 means PREADY never comes.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic slverr);
    int s, off, done_c, k, b;
    logic ok, fail_end;
    logic [3:0]  e_strb;
    logic [31:0] e_wd, e_rd;
    s   = size_of(f3);
    off = int'(addr[1:0]);
    ok  = (s != 0) && !(we && f3[2]) && ((off % ((s == 0) ? 1 : s)) == 0);
    e_strb = 4'b0000;
    e_wd   = 32'h0;
    e_rd   = 32'h0;
    b      = int'(addr & 32'h3C);
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        e_strb[i]      = we && (i >= off) && (i < off + s);
        e_wd[8*i +: 8] = wdata[8*(i % s) +: 8];
      end
      for (int j = 0; j < s; j++) e_rd[8*j +: 8] = mem_b[b + off + j];
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    fail_end   = (waits < 0) || slverr;
    if (!ok) begin
      @(negedge clk); #1;
      chk("rej_stall", 32'(stall), 32'(1'b0));
      chk("rej_err",   32'(lsu_err), 32'(1'b1));
      chk("rej_psel",  32'(PSEL), 32'(1'b0));
      chk("rej_valid", 32'(rdata_valid), 32'(1'b0));
      @(posedge clk); #1;
    end else begin
      done_c = (waits < 0) ? (1 + T) : (2 + waits);
      for (int c = 0; c <= done_c; c++) begin
        @(negedge clk);
        if (c >= 2) begin
          k       = c - 2;
          PREADY  = (waits >= 0) && (k == waits);
          PSLVERR = PREADY && slverr;
          PRDATA  = mem_word(addr);
        end
        #1;
        chk("psel",    32'(PSEL),    32'(c >= 1));
        chk("penable", 32'(PENABLE), 32'(c >= 2));
        if (c == 1) begin
          chk("paddr",  PADDR, addr & 32'hFFFF_FFFC);
          chk("pwrite", 32'(PWRITE), 32'(we));
          chk("pstrb",  32'(PSTRB), 32'(e_strb));
          if (we) chk("pwdata", PWDATA, e_wd);
        end
        if (c < done_c) begin
          chk("stall_hi",  32'(stall), 32'(1'b1));
          chk("err_lo",    32'(lsu_err), 32'(1'b0));
          chk("valid_lo",  32'(rdata_valid), 32'(1'b0));
        end else begin
          chk("stall_end", 32'(stall), 32'(1'b0));
          chk("err_end",   32'(lsu_err), 32'(fail_end));
          chk("valid_end", 32'(rdata_valid), 32'(!fail_end && !we));
          if (slverr && waits >= 0) chk("rdata_err", rdata, 32'h0);
          else if (!fail_end && !we) chk("rdata", rdata, e_rd);
        end
        @(posedge clk); #1;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      if (!fail_end && we)
        for (int i = 0; i < 4; i++) if (e_strb[i]) mem_b[b+i] = e_wd[8*i +: 8];
      if (!fail_end && !we) last_load = e_rd;
    end
    req_valid = 1'b0;
    $display("txn we=%0d f3=%0d addr=%h wdata=%h waits=%0d slverr=%0d legal=%0d exp_rd=%h",
             we, f3, addr, wdata, waits, slverr, ok, e_rd);
    @(negedge clk); #1;
    chk("idle_psel",  32'(PSEL), 32'(1'b0));
    chk("idle_stall", 32'(stall), 32'(1'b0));
    chk("rdata_hold", rdata, last_load);
    @(posedge clk); #1;
  endtask

  initial begin
    int r, w;
    logic        rwe, rerr;
    logic [2:0]  rf3;
    logic [31:0] ra;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    last_load = 32'h0;
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel",    32'(PSEL), 32'(1'b0));
    chk("rst_penable", 32'(PENABLE), 32'(1'b0));
    chk("rst_pwrite",  32'(PWRITE), 32'(1'b0));
    chk("rst_paddr",   PADDR, 32'h0);
    chk("rst_pwdata",  PWDATA, 32'h0);
    chk("rst_pstrb",   32'(PSTRB), 32'h0);
    chk("rst_rdata",   rdata, 32'h0);
    chk("rst_valid",   32'(rdata_valid), 32'(1'b0));
    chk("rst_err",     32'(lsu_err), 32'(1'b0));
    chk("rst_stall",   32'(stall), 32'(1'b0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b0);
    run_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 1'b0);
    set_word(32'h2000, 32'h8001_1234);
    run_txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 2, 1'b0);
    run_txn(1'b0, 3'b010, 32'h0000_2001, 32'h0, 0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h0000_2004, 32'h0, 0, 1'b1);
    run_txn(1'b0, 3'b010, 32'h0000_2008, 32'h0, -1, 1'b0);
    run_txn(1'b1, 3'b100, 32'h0000_200C, 32'h1234_5678, 0, 1'b0);
    run_txn(1'b0, 3'b011, 32'h0000_2010, 32'h0, 0, 1'b0);

    // Reset asserted while the transfer sits in ACCESS with the request held.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_3014; req_wdata = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("pre_rst_penable", 32'(PENABLE), 32'(1'b1));
    reset = 1'b0;
    #1;
    chk("mid_rst_psel",    32'(PSEL), 32'(1'b0));
    chk("mid_rst_penable", 32'(PENABLE), 32'(1'b0));
    chk("mid_rst_stall",   32'(stall), 32'(1'b0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    last_load = 32'h0;
    $display("txn reset during ACCESS addr=00003014");
    @(posedge clk); #1;
    run_txn(1'b0, 3'b010, 32'h0000_3014, 32'h0, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rwe  = 1'($urandom_range(0, 1));
      rf3  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      r    = int'($urandom_range(0, 9));
      w    = (r == 9) ? -1 : (r % 4);
      rerr = ($urandom_range(0, 7) == 0);
      run_txn(rwe, rf3, ra, $urandom, w, rerr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
